ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the 5-stage MIPS pipeline, directly downstream of the ALU-control decoder.
//  Consumes the 4-bit ALU control code plus ID/EX operands, resolves forwarding, computes the result.
//  Captures result and control into the EX/MEM pipeline register, with stall, flush and bubble handling.
// PARAMETERS
//  DW      32  datapath width, fixed at 32 for MIPS-I
//  RW      5   register-specifier width
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  stall           in   1   hold EX/MEM register contents (hazard unit)
//  flush           in   1   load bubble into EX/MEM (branch / exception)
//  in_valid        in   1   ID/EX slot holds a real instruction
//  alu_ctr         in   4   ALU control code from decoder
//  rs_data         in   DW  register-file read A
//  rt_data         in   DW  register-file read B
//  imm32           in   DW  sign/zero-extended immediate
//  alu_src         in   1   1 = operand B is imm32
//  fwd_a, fwd_b    in   2   forward select: 00 reg file, 01 WB data, 10 EX/MEM result
//  wb_data         in   DW  write-back value for forwarding
//  rd_in           in   RW  destination register
//  reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in 1 each  ID/EX control
//  ex_valid        out  1   EX/MEM slot valid
//  ex_result       out  DW  registered ALU result (also forwarding source 10)
//  ex_zero         out  1   registered (ALU result == 0)
//  ex_store_data   out  DW  registered forwarded B, before alu_src mux
//  ex_rd           out  RW  registered destination
//  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out 1 each  registered control
// BEHAVIOUR
//  - Reset (rst_n low, async): every output 0; register clears immediately, no clock needed.
//  - Operand A = mux(fwd_a); forwarded B = mux(fwd_b); operand B = alu_src ? imm32 : forwarded B.
//  - fwd select 11 behaves as 00.
//  - ALU ops by code:
//      0000 A&B;  0001 A|B;  0010 A+B, mod 2^32, no overflow trap
//      0110 A-B, mod 2^32;  0111 signed A<B ? 1 : 0;  0011 unsigned A<B ? 1 : 0
//      0100 lui: B<<16, low half zero, A ignored
//      any other code: result 0
//  - Latency: one cycle. Inputs at edge N appear on ex_* after edge N.
//  - Priority per edge: rst_n > flush > stall > load.
//  - flush: ex_valid=0; all ex_* control bits 0; data fields 0. Applies even when stall is high.
//  - stall (no flush): all ex_* hold; the combinational ALU keeps evaluating.
//  - load with in_valid=0: bubble, identical to flush.
//  - load with in_valid=1: capture result, zero flag, store data, rd and control; ex_valid=1.
//  - rd_in==0 with reg_write_in=1: captured as-is; write suppression is the register file's job.
//  - Forwarding source 10 reads the current registered ex_result, so back-to-back dependents work.
//  - Reset deasserted mid-stream: first edge after release performs a normal load.
// STRUCTURE
//  - Shared package mips_pkg: ALU control code constants (ALU_AND..ALU_LUI), forward-select constants.
//    ex_stage and the ALU-control decoder both import it.
//  - One sub-module: alu_core, combinational (a, b, alu_ctr -> result, zero).
//  - ex_stage holds the forwarding muxes and the EX/MEM register.
// TESTING
//  - Reset: drive rst_n=0 mid-cycle -> all ex_* read 0 before the next clk edge.
//  - Arithmetic: ctr=0010, A=FFFFFFFF, B=1 -> result 0, zero=1.
//    ctr=0110, A=5, B=7 -> FFFFFFFE.
//  - Compare/lui: ctr=0111, A=FFFFFFFF, B=1 -> 1; ctr=0011 same operands -> 0.
//    ctr=0100, imm32=00001234, alu_src=1 -> 12340000.
//  - Forwarding chain: add 3+4 then fwd_a=10 with B=10 -> second result 0000_0011.
//    fwd_b=01, wb_data=AA, alu_src=1 -> ex_store_data=AA.
//  - Stall/flush: stall=1 for 3 cycles -> ex_* unchanged.
//    stall=1 & flush=1 -> ex_valid=0, ex_reg_write=0, ex_mem_write=0.
//  - Bubble/illegal: in_valid=0 -> ex_valid=0, controls 0.
//    ctr=1111, in_valid=1 -> ex_result=0, ex_zero=1, ex_valid=1.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_pkg                                               |
// | Description : Shared ALU control codes and forward-select encodings  |
// |               for the MIPS pipeline (decoder and execute stage).     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mips_pkg;

  // ALU control codes produced by the ALU-control decoder
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  // Forward-select encodings; 2'b11 is unused and treated as register file
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_core                                               |
// | Description : Combinational MIPS-I ALU: and/or/add/sub/slt/sltu/lui. |
// |               Unknown control codes yield a zero result.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_core
  import mips_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    alu_ctr,
  output logic [DW-1:0] result,
  output logic          zero
);

  logic [DW-1:0] w_result;

  // Select the operation; arithmetic wraps, no overflow detection
  always_comb begin
    w_result = '0;
    case (alu_ctr)
      ALU_AND:  w_result = a & b;
      ALU_OR:   w_result = a | b;
      ALU_ADD:  w_result = a + b;
      ALU_SUB:  w_result = a - b;
      ALU_SLT:  w_result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_result = {{(DW-1){1'b0}}, (a < b)};
      ALU_LUI:  w_result = b << 16;
      default:  w_result = '0;
    endcase
  end

  assign result = w_result;
  assign zero   = (w_result == '0);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ex_stage                                               |
// | Description : MIPS execute stage: operand forwarding, ALU, and the   |
// |               EX/MEM pipeline register with stall/flush/bubble.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [3:0]    alu_ctr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [DW-1:0] imm32,
  input  logic          alu_src,
  input  logic [1:0]    fwd_a,
  input  logic [1:0]    fwd_b,
  input  logic [DW-1:0] wb_data,
  input  logic [RW-1:0] rd_in,
  input  logic          reg_write_in,
  input  logic          mem_read_in,
  input  logic          mem_write_in,
  input  logic          mem_to_reg_in,
  output logic          ex_valid,
  output logic [DW-1:0] ex_result,
  output logic          ex_zero,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_fwd_b;
  logic [DW-1:0] w_op_b;
  logic [DW-1:0] w_alu_result;
  logic          w_alu_zero;
  logic          w_clear;

  logic          r_valid;
  logic [DW-1:0] r_result;
  logic          r_zero;
  logic [DW-1:0] r_store_data;
  logic [RW-1:0] r_rd;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_mem_to_reg;

  // Forwarding muxes; EX/MEM source is our own registered result
  always_comb begin
    w_op_a = rs_data;
    case (fwd_a)
      FWD_WB:  w_op_a = wb_data;
      FWD_MEM: w_op_a = r_result;
      default: w_op_a = rs_data;
    endcase
    w_fwd_b = rt_data;
    case (fwd_b)
      FWD_WB:  w_fwd_b = wb_data;
      FWD_MEM: w_fwd_b = r_result;
      default: w_fwd_b = rt_data;
    endcase
    w_op_b = alu_src ? imm32 : w_fwd_b;
  end

  alu_core #(.DW(DW)) u_alu (
    .a       (w_op_a),
    .b       (w_op_b),
    .alu_ctr (alu_ctr),
    .result  (w_alu_result),
    .zero    (w_alu_zero)
  );

  // A bubble enters on flush (even when stalled) or on an empty un-stalled slot
  assign w_clear = flush | (~stall & ~in_valid);

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_clear) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      r_valid      <= 1'b1;
      r_result     <= w_alu_result;
      r_zero       <= w_alu_zero;
      r_store_data <= w_fwd_b;
      r_rd         <= rd_in;
      r_reg_write  <= reg_write_in;
      r_mem_read   <= mem_read_in;
      r_mem_write  <= mem_write_in;
      r_mem_to_reg <= mem_to_reg_in;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_result     = r_result;
  assign ex_zero       = r_zero;
  assign ex_store_data = r_store_data;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ex_stage                                            |
// | Description : Directed, table-driven bench for the execute stage.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, in_valid, alu_src;
  logic [3:0]  alu_ctr;
  logic [31:0] rs_data, rt_data, imm32, wb_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in;
  logic        ex_valid, ex_zero;
  logic [31:0] ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_ctr(alu_ctr), .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32),
    .alu_src(alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // ctl / e_ctl packing: {reg_write, mem_read, mem_write, mem_to_reg}
  typedef struct {
    logic        valid;
    logic [3:0]  ctr;
    logic [31:0] rs, rt, imm;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] wb;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic [31:0] e_res;
    logic        e_zero;
    logic [31:0] e_store;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic [3:0]  e_ctl;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.valid; alu_ctr = v.ctr; rs_data = v.rs; rt_data = v.rt;
    imm32 = v.imm; alu_src = v.src; fwd_a = v.fa; fwd_b = v.fb; wb_data = v.wb;
    rd_in = v.rd;
    {reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in} = v.ctl;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, ".result"}, ex_result, v.e_res);
    chk({tag, ".zero"},   {31'd0, ex_zero}, {31'd0, v.e_zero});
    chk({tag, ".store"},  ex_store_data, v.e_store);
    chk({tag, ".valid"},  {31'd0, ex_valid}, {31'd0, v.e_valid});
    chk({tag, ".rd"},     {27'd0, ex_rd}, {27'd0, v.e_rd});
    chk({tag, ".ctl"},    {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                          {28'd0, v.e_ctl});
  endtask

  // Quick helper for hand sequences: add-style instruction, no forwarding
  function automatic vec_t ins(input logic [3:0] ctr, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [4:0] rd, input logic [3:0] ctl);
    vec_t v;
    v = '{1'b1, ctr, rs, rt, 32'h0, 1'b0, 2'b00, 2'b00, 32'h0, rd, ctl,
          32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 4'h0};
    return v;
  endfunction

  initial begin
    vec_t v;
    //          vld ctr      rs            rt            imm           src fa     fb     wb            rd     ctl      | e_res         e_z   e_store       e_v   e_rd   e_ctl
    vecs[0]  = '{1, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd3,  4'b1000, 32'h00000000, 1'b1, 32'h00000001, 1'b1, 5'd3,  4'b1000};
    vecs[1]  = '{1, 4'b0110, 32'h00000005, 32'h00000007, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd4,  4'b1000, 32'hFFFFFFFE, 1'b0, 32'h00000007, 1'b1, 5'd4,  4'b1000};
    vecs[2]  = '{1, 4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd5,  4'b1000, 32'h00000001, 1'b0, 32'h00000001, 1'b1, 5'd5,  4'b1000};
    vecs[3]  = '{1, 4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd6,  4'b1000, 32'h00000000, 1'b1, 32'h00000001, 1'b1, 5'd6,  4'b1000};
    vecs[4]  = '{1, 4'b0100, 32'h00000009, 32'h00000055, 32'h00001234, 1, 2'b00, 2'b00, 32'h0,        5'd7,  4'b1000, 32'h12340000, 1'b0, 32'h00000055, 1'b1, 5'd7,  4'b1000};
    vecs[5]  = '{1, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd8,  4'b0000, 32'h0000F000, 1'b0, 32'h0000FF00, 1'b1, 5'd8,  4'b0000};
    vecs[6]  = '{1, 4'b0001, 32'h0000F0F0, 32'h0000FF00, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd9,  4'b1000, 32'h0000FFF0, 1'b0, 32'h0000FF00, 1'b1, 5'd9,  4'b1000};
    vecs[7]  = '{1, 4'b1111, 32'h00000123, 32'h00000456, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd10, 4'b1000, 32'h00000000, 1'b1, 32'h00000456, 1'b1, 5'd10, 4'b1000};
    vecs[8]  = '{0, 4'b0010, 32'h00000001, 32'h00000002, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd11, 4'b1111, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 5'd0,  4'b0000};
    vecs[9]  = '{1, 4'b0010, 32'h00000001, 32'h00000002, 32'h0,        0, 2'b00, 2'b00, 32'h0,        5'd0,  4'b1000, 32'h00000003, 1'b0, 32'h00000002, 1'b1, 5'd0,  4'b1000};
    vecs[10] = '{1, 4'b0010, 32'h00000010, 32'h00000020, 32'h0,        0, 2'b11, 2'b11, 32'h0000FFFF, 5'd12, 4'b1000, 32'h00000030, 1'b0, 32'h00000020, 1'b1, 5'd12, 4'b1000};
    vecs[11] = '{1, 4'b0010, 32'h00000100, 32'h00000ABC, 32'h00000008, 1, 2'b00, 2'b00, 32'h0,        5'd13, 4'b1101, 32'h00000108, 1'b0, 32'h00000ABC, 1'b1, 5'd13, 4'b1101};
    vecs[12] = '{1, 4'b0010, 32'h00000200, 32'h00000077, 32'h00000004, 1, 2'b00, 2'b00, 32'h0,        5'd0,  4'b0010, 32'h00000204, 1'b0, 32'h00000077, 1'b1, 5'd0,  4'b0010};

    // Reset state
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(ins(4'b0010, 32'h0, 32'h0, 5'd0, 4'b0000));
    repeat (2) @(negedge clk);
    v = '{0, 4'b0, 32'h0, 32'h0, 32'h0, 0, 2'b00, 2'b00, 32'h0, 5'd0, 4'b0,
          32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 4'b0};
    check_vec(v, "reset");
    rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Forwarding chain: 3+4, then EX/MEM result forwarded as A
    drive(ins(4'b0010, 32'd3, 32'd4, 5'd1, 4'b1000));
    @(negedge clk);
    chk("fwd.first", ex_result, 32'h00000007);
    v = ins(4'b0010, 32'hDEAD0000, 32'd10, 5'd2, 4'b1000);
    v.fa = 2'b10;
    drive(v);
    @(negedge clk);
    chk("fwd.exmem_a", ex_result, 32'h00000011);
    // WB forwarded on B; store data takes forwarded B, operand B takes imm
    v = ins(4'b0010, 32'd1, 32'h12345678, 5'd3, 4'b1010);
    v.fb = 2'b01; v.wb = 32'h000000AA; v.src = 1'b1; v.imm = 32'd5;
    drive(v);
    @(negedge clk);
    chk("fwd.wb_store", ex_store_data, 32'h000000AA);
    chk("fwd.wb_result", ex_result, 32'h00000006);

    // Stall for three cycles with changing inputs: everything holds
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(ins(4'b0110, 32'd50 + c, 32'd1, 5'd20, 4'b0101));
      @(negedge clk);
      chk($sformatf("stall%0d.result", c), ex_result, 32'h00000006);
      chk($sformatf("stall%0d.store", c), ex_store_data, 32'h000000AA);
      chk($sformatf("stall%0d.rd", c), {27'd0, ex_rd}, 32'd3);
      chk($sformatf("stall%0d.ctl", c),
          {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'hA);
      chk($sformatf("stall%0d.valid", c), {31'd0, ex_valid}, 32'd1);
    end

    // Flush wins over stall
    flush = 1'b1;
    @(negedge clk);
    chk("flush.valid", {31'd0, ex_valid}, 32'd0);
    chk("flush.reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("flush.mem_write", {31'd0, ex_mem_write}, 32'd0);
    chk("flush.result", ex_result, 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-cycle, then normal load on the first edge after release
    drive(ins(4'b0010, 32'd1, 32'd1, 5'd1, 4'b1000));
    @(negedge clk);
    chk("prereset.result", ex_result, 32'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst.result", ex_result, 32'd0);
    chk("async_rst.rd", {27'd0, ex_rd}, 32'd0);
    chk("async_rst.reg_write", {31'd0, ex_reg_write}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(ins(4'b0010, 32'd7, 32'd8, 5'd2, 4'b1000));
    @(negedge clk);
    chk("postrst.result", ex_result, 32'd15);
    chk("postrst.valid", {31'd0, ex_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
